// File: rtl/p2p_egress_enqueue_if.sv
// P2P forward stream: valid/last/data/head handshake into the egress enqueue stage.
// The head field is meaningful on the first beat of a packet only.
interface p2p_egress_enqueue_if #(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned HeadWidth = 64
);
  logic                 p2p_rx_valid;
  logic                 p2p_rx_last;
  logic [DataWidth-1:0] p2p_rx_data;
  logic [HeadWidth-1:0] p2p_rx_head;
  logic                 p2p_rx_ready;

  modport master (
    output p2p_rx_valid,
    output p2p_rx_last,
    output p2p_rx_data,
    output p2p_rx_head,
    input  p2p_rx_ready
  );

  modport slave (
    input  p2p_rx_valid,
    input  p2p_rx_last,
    input  p2p_rx_data,
    input  p2p_rx_head,
    output p2p_rx_ready
  );
endinterface

// File: rtl/p2p_egress_enqueue.sv
// Packs P2P stream beats into 288-bit egress-queue entries, steering each packet whole to queue 0/1.
// Optional length checking (beat counter, DROP state, error counter) under P2P_ENQ_LEN_CHECK_EN.
module p2p_egress_enqueue #(
  parameter int unsigned EGRESS_QUEUE_WIDTH = 288,
  parameter int unsigned C_DATA_WIDTH       = 256,
  parameter int unsigned UPPER_HEAD_WIDTH   = 64,
  parameter int unsigned DEV_WIDTH          = 3,
  parameter int unsigned ERR_CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    iv_dst_queue_map,
  p2p_egress_enqueue_if.slave           rx,
  input  logic                          i_queue_0_prog_full,
  output logic                          o_queue_0_wr_en,
  output logic [EGRESS_QUEUE_WIDTH-1:0] ov_queue_0_data,
  input  logic                          i_queue_1_prog_full,
  output logic                          o_queue_1_wr_en,
  output logic [EGRESS_QUEUE_WIDTH-1:0] ov_queue_1_data,
  output logic [ERR_CNT_WIDTH-1:0]      ov_err_cnt,
  output logic                          o_busy
);
  localparam int unsigned LenWidth  = 16;
  localparam int unsigned KeepWidth = 5;
  localparam int unsigned PadWidth  =
      EGRESS_QUEUE_WIDTH - 2 * DEV_WIDTH - LenWidth - KeepWidth - 2 - C_DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

  state_e                          state_q, state_d;
  logic [DEV_WIDTH-1:0]            dst_q, dst_d, src_q, src_d;
  logic [LenWidth-1:0]             len_q, len_d;
  logic                            tgt_q, tgt_d;
  logic                            wr0_q, wr0_d, wr1_q, wr1_d;
  logic [EGRESS_QUEUE_WIDTH-1:0]   entry_q, entry_d;

  logic [DEV_WIDTH-1:0] head_dst, head_src, cur_dst, cur_src;
  logic [LenWidth-1:0]  head_len, cur_len, len_m1;
  logic                 head_tgt, cur_tgt, is_head, rx_ready, accept;
  logic                 end_flag, write, end_to_drop;
  logic [KeepWidth-1:0] keep;
  logic                 unused_bits;

  assign head_len = rx.p2p_rx_head[LenWidth-1:0];
  assign head_src = rx.p2p_rx_head[32 +: DEV_WIDTH];
  assign head_dst = rx.p2p_rx_head[35 +: DEV_WIDTH];
  assign head_tgt = iv_dst_queue_map[head_dst];

  // In IDLE the current beat is the head, so its fields are used directly rather than the latches.
  assign is_head = (state_q == StIdle);
  assign cur_len = is_head ? head_len : len_q;
  assign cur_dst = is_head ? head_dst : dst_q;
  assign cur_src = is_head ? head_src : src_q;
  assign cur_tgt = is_head ? head_tgt : tgt_q;
  assign len_m1  = cur_len - LenWidth'(1);
  assign keep    = end_flag ? len_m1[KeepWidth-1:0] : '1;

  // Admission is decided once per packet, at the head beat.
  assign rx_ready        = is_head ? !(head_tgt ? i_queue_1_prog_full : i_queue_0_prog_full) : 1'b1;
  assign rx.p2p_rx_ready = rx_ready;
  assign accept          = rx.p2p_rx_valid && rx_ready;

  assign unused_bits = ^{rx.p2p_rx_head[UPPER_HEAD_WIDTH-1:38], rx.p2p_rx_head[31:16],
                         len_m1[LenWidth-1:KeepWidth]};

`ifdef P2P_ENQ_LEN_CHECK_EN
  localparam int unsigned CntWidth = 12;

  logic [CntWidth-1:0]      cnt_q, cnt_d, beat_n, exp_beats;
  logic [LenWidth:0]        len_round;
  logic                     zero_len, forced_end, err_evt, unused_round;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

  assign len_round    = {1'b0, cur_len} + (LenWidth + 1)'(31);
  assign exp_beats    = len_round[LenWidth:5];
  assign unused_round = ^len_round[4:0];
  assign beat_n       = is_head ? CntWidth'(1) : cnt_q + CntWidth'(1);
  assign zero_len     = (cur_len == '0);
  assign forced_end   = (beat_n == exp_beats);
  assign end_flag     = rx.p2p_rx_last || forced_end;
  assign write        = accept && (state_q != StDrop) && !zero_len;
  // Early last and missing last both show up as last disagreeing with the expected-count hit.
  assign err_evt      = accept && (state_q != StDrop) &&
                        (zero_len || (rx.p2p_rx_last != forced_end));
  assign end_to_drop  = !rx.p2p_rx_last && (zero_len || forced_end);
  assign cnt_d        = (accept && (state_q != StDrop)) ? beat_n : cnt_q;
  assign err_d        = (err_evt && (err_q != '1)) ? err_q + ERR_CNT_WIDTH'(1) : err_q;
  assign ov_err_cnt   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign end_flag    = rx.p2p_rx_last;
  assign write       = accept;
  assign end_to_drop = 1'b0;
  assign ov_err_cnt  = '0;
`endif

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (rx.p2p_rx_last) begin
        state_d = StIdle;
      end else if ((state_q == StDrop) || end_to_drop) begin
        state_d = StDrop;
      end else begin
        state_d = StFwd;
      end
    end
  end

  always_comb begin
    dst_d   = dst_q;
    src_d   = src_q;
    len_d   = len_q;
    tgt_d   = tgt_q;
    entry_d = entry_q;
    wr0_d   = write && !cur_tgt;
    wr1_d   = write && cur_tgt;
    if (accept && is_head) begin
      dst_d = head_dst;
      src_d = head_src;
      len_d = head_len;
      tgt_d = head_tgt;
    end
    if (write) begin
      entry_d = {PadWidth'(0), cur_dst, cur_src, cur_len, keep, end_flag, is_head,
                 rx.p2p_rx_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dst_q   <= '0;
      src_q   <= '0;
      len_q   <= '0;
      tgt_q   <= 1'b0;
      wr0_q   <= 1'b0;
      wr1_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      len_q   <= len_d;
      tgt_q   <= tgt_d;
      wr0_q   <= wr0_d;
      wr1_q   <= wr1_d;
      entry_q <= entry_d;
    end
  end

  assign o_queue_0_wr_en = wr0_q;
  assign o_queue_1_wr_en = wr1_q;
  assign ov_queue_0_data = entry_q;
  assign ov_queue_1_data = entry_q;
  assign o_busy          = (state_q != StIdle);
endmodule

// File: tb/tb_p2p_egress_enqueue.sv
// Bench for p2p_egress_enqueue: head-decode vector table, directed multi-cycle cases and
// randomized packets checked against a packet-level reference model.
module tb_p2p_egress_enqueue;
  localparam int unsigned EQW = 288;
  localparam int unsigned DW  = 256;
  localparam int unsigned HW  = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     map = 8'h00;
  logic           pf0 = 1'b0, pf1 = 1'b0;
  logic           wr0, wr1, busy;
  logic [EQW-1:0] d0, d1;
  logic [15:0]    err;
  bit             rand_pf = 1'b0;

  always #5 clk = ~clk;

  p2p_egress_enqueue_if #(.DataWidth(DW), .HeadWidth(HW)) rx ();

  p2p_egress_enqueue dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .iv_dst_queue_map    (map),
    .rx                  (rx.slave),
    .i_queue_0_prog_full (pf0),
    .o_queue_0_wr_en     (wr0),
    .ov_queue_0_data     (d0),
    .i_queue_1_prog_full (pf1),
    .o_queue_1_wr_en     (wr1),
    .ov_queue_1_data     (d1),
    .ov_err_cnt          (err),
    .o_busy              (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [EQW-1:0] act, input logic [EQW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Writes observed on each queue, plus write-latency and exclusivity checks.
  logic [EQW-1:0] act_q0[$], act_q1[$], exp_q0[$], exp_q1[$];
  logic acc_prev = 1'b0;
  always @(negedge clk) begin
    if (wr0 || wr1) begin
      check("wr_one_cycle_after_accept", acc_prev, 1'b1);
      check("wr_exclusive", wr0 && wr1, 1'b0);
      if (wr0) act_q0.push_back(d0);
      if (wr1) act_q1.push_back(d1);
    end
    acc_prev <= rst_n && rx.p2p_rx_valid && rx.p2p_rx_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [EQW-1:0] mk_entry(input logic [2:0] dst, input logic [2:0] src,
      input logic [15:0] len, input logic [4:0] keep, input logic endf, input logic startf,
      input logic [DW-1:0] data);
    return {3'b000, dst, src, len, keep, endf, startf, data};
  endfunction

  function automatic logic [HW-1:0] mk_head(input logic [2:0] dst, input logic [2:0] src,
      input logic [15:0] len);
    logic [HW-1:0] h;
    h = {$urandom, $urandom};
    h[15:0]  = len;
    h[34:32] = src;
    h[37:35] = dst;
    return h;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [4:0] end_keep(input int len);
    return 5'((len + 31) % 32);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for ready, return 1 ns after the accepting edge.
  task automatic send_beat(input logic [DW-1:0] data, input logic [HW-1:0] head,
      input logic last);
    bit ok = 1'b0;
    rx.p2p_rx_valid = 1'b1;
    rx.p2p_rx_data  = data;
    rx.p2p_rx_head  = head;
    rx.p2p_rx_last  = last;
    for (int i = 0; i < 300; i++) begin
      if (rand_pf) begin
        pf0 = ($urandom_range(0, 3) == 0);
        pf1 = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      if (rx.p2p_rx_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout actual=0 required=1");
    end
    step();
    rx.p2p_rx_valid = 1'b0;
    rx.p2p_rx_head  = {$urandom, $urandom};
  endtask

  typedef struct {
    logic [7:0]  map;
    logic [2:0]  dst;
    logic [2:0]  src;
    logic [15:0] len;
    logic        pf0;
    logic        pf1;
    logic        exp_ready;
    logic        exp_q;
    logic [4:0]  exp_keep;
  } tv_t;

  tv_t tv[8];
  logic [DW-1:0] bd[4];
  int err_exp;

  initial begin
    tv[0] = '{8'h00, 3'd0, 3'd5, 16'd1,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    tv[1] = '{8'h01, 3'd0, 3'd2, 16'd32, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31};
    tv[2] = '{8'h80, 3'd7, 3'd1, 16'd17, 1'b1, 1'b0, 1'b1, 1'b1, 5'd16};
    tv[3] = '{8'h80, 3'd6, 3'd1, 16'd17, 1'b1, 1'b0, 1'b0, 1'b0, 5'd16};
    tv[4] = '{8'hFF, 3'd3, 3'd4, 16'd5,  1'b0, 1'b1, 1'b0, 1'b1, 5'd4};
    tv[5] = '{8'hFF, 3'd4, 3'd7, 16'd31, 1'b1, 1'b0, 1'b1, 1'b1, 5'd30};
    tv[6] = '{8'h55, 3'd2, 3'd3, 16'd8,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7};
    tv[7] = '{8'h55, 3'd1, 3'd6, 16'd20, 1'b0, 1'b1, 1'b1, 1'b0, 5'd19};

    rx.p2p_rx_valid = 1'b0;
    rx.p2p_rx_last  = 1'b0;
    rx.p2p_rx_data  = '0;
    rx.p2p_rx_head  = '0;

    // Reset state.
    repeat (3) step();
    check("reset_wr0", wr0, 1'b0);
    check("reset_wr1", wr1, 1'b0);
    check("reset_data0", d0, '0);
    check("reset_data1", d1, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, '0);
    check("reset_ready", rx.p2p_rx_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Head decode / admission table: single-beat packets.
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] dat;
      logic [EQW-1:0] e;
      map = tv[i].map;
      pf0 = tv[i].pf0;
      pf1 = tv[i].pf1;
      dat = rand_data();
      rx.p2p_rx_valid = 1'b1;
      rx.p2p_rx_last  = 1'b1;
      rx.p2p_rx_data  = dat;
      rx.p2p_rx_head  = mk_head(tv[i].dst, tv[i].src, tv[i].len);
      @(negedge clk);
      check($sformatf("tv%0d_ready", i), rx.p2p_rx_ready, tv[i].exp_ready);
      step();
      rx.p2p_rx_valid = 1'b0;
      e = mk_entry(tv[i].dst, tv[i].src, tv[i].len, tv[i].exp_keep, 1'b1, 1'b1, dat);
      if (tv[i].exp_ready) begin
        check($sformatf("tv%0d_wr0", i), wr0, !tv[i].exp_q);
        check($sformatf("tv%0d_wr1", i), wr1, tv[i].exp_q);
        check($sformatf("tv%0d_entry", i), tv[i].exp_q ? d1 : d0, e);
      end else begin
        check($sformatf("tv%0d_no_wr", i), {wr0, wr1}, 2'b00);
      end
      step();
    end
    pf0 = 1'b0;
    pf1 = 1'b0;
    act_q0.delete();
    act_q1.delete();

    // Two-beat packet to queue 0.
    map = 8'h00;
    for (int b = 0; b < 2; b++) begin
      bd[b] = rand_data();
      send_beat(bd[b], mk_head(3'd2, 3'd1, 16'd64), b == 1);
      check($sformatf("t1_wr0_beat%0d", b), wr0, 1'b1);
    end
    step();
    check("t1_q0_count", act_q0.size(), 2);
    check("t1_q1_count", act_q1.size(), 0);
    if (act_q0.size() == 2) begin
      check("t1_entry0", act_q0[0], mk_entry(3'd2, 3'd1, 16'd64, 5'd31, 1'b0, 1'b1, bd[0]));
      check("t1_entry1", act_q0[1], mk_entry(3'd2, 3'd1, 16'd64, 5'd31, 1'b1, 1'b0, bd[1]));
    end
    act_q0.delete();

    // Head held off by queue 1 prog_full, then admitted.
    map = 8'h04;
    pf1 = 1'b1;
    bd[0] = rand_data();
    rx.p2p_rx_valid = 1'b1;
    rx.p2p_rx_last  = 1'b1;
    rx.p2p_rx_data  = bd[0];
    rx.p2p_rx_head  = mk_head(3'd2, 3'd3, 16'd10);
    @(negedge clk);
    check("t2_ready_blocked", rx.p2p_rx_ready, 1'b0);
    repeat (3) step();
    check("t2_no_write", act_q1.size() + act_q0.size(), 0);
    pf1 = 1'b0;
    @(negedge clk);
    check("t2_ready_open", rx.p2p_rx_ready, 1'b1);
    step();
    rx.p2p_rx_valid = 1'b0;
    check("t2_wr1", wr1, 1'b1);
    check("t2_entry", d1, mk_entry(3'd2, 3'd3, 16'd10, 5'd9, 1'b1, 1'b1, bd[0]));
    step();
    act_q1.delete();

    // prog_full rising mid-packet does not stall the packet.
    map = 8'h00;
    for (int b = 0; b < 4; b++) begin
      bd[b] = rand_data();
      send_beat(bd[b], mk_head(3'd1, 3'd0, 16'd128), b == 3);
      if (b == 0) begin
        pf0 = 1'b1;
        @(negedge clk);
        check("t3_ready_fwd", rx.p2p_rx_ready, 1'b1);
        check("t3_busy", busy, 1'b1);
        step();
      end
    end
    step();
    pf0 = 1'b0;
    check("t3_q0_count", act_q0.size(), 4);
    for (int b = 0; b < 4; b++) begin
      if (b < act_q0.size())
        check($sformatf("t3_entry%0d", b), act_q0[b],
              mk_entry(3'd1, 3'd0, 16'd128, 5'd31, b == 3, b == 0, bd[b]));
    end
    act_q0.delete();

    // len=40 sent as three beats.
    for (int b = 0; b < 3; b++) begin
      bd[b] = rand_data();
      send_beat(bd[b], mk_head(3'd5, 3'd2, 16'd40), b == 2);
    end
    step();
    check("t4_busy", busy, 1'b0);
`ifdef P2P_ENQ_LEN_CHECK_EN
    check("t4_q0_count", act_q0.size(), 2);
    if (act_q0.size() == 2)
      check("t4_entry1", act_q0[1], mk_entry(3'd5, 3'd2, 16'd40, 5'd7, 1'b1, 1'b0, bd[1]));
    check("t4_err", err, 16'd1);
`else
    check("t4_q0_count", act_q0.size(), 3);
    if (act_q0.size() == 3) begin
      check("t4_entry1", act_q0[1], mk_entry(3'd5, 3'd2, 16'd40, 5'd31, 1'b0, 1'b0, bd[1]));
      check("t4_entry2", act_q0[2], mk_entry(3'd5, 3'd2, 16'd40, 5'd7, 1'b1, 1'b0, bd[2]));
    end
    check("t4_err", err, 16'd0);
`endif
    act_q0.delete();

    // Zero-length single beat.
    bd[0] = rand_data();
    send_beat(bd[0], mk_head(3'd0, 3'd4, 16'd0), 1'b1);
    step();
    check("t5_busy", busy, 1'b0);
`ifdef P2P_ENQ_LEN_CHECK_EN
    check("t5_no_write", act_q0.size(), 0);
    check("t5_err", err, 16'd2);
`else
    check("t5_q0_count", act_q0.size(), 1);
    if (act_q0.size() == 1)
      check("t5_entry", act_q0[0], mk_entry(3'd0, 3'd4, 16'd0, 5'd31, 1'b1, 1'b1, bd[0]));
`endif
    act_q0.delete();

    // Reset in the middle of a packet.
    for (int b = 0; b < 2; b++) send_beat(rand_data(), mk_head(3'd3, 3'd4, 16'd128), 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr", {wr0, wr1}, 2'b00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_err", err, '0);
    check("t6_partial_count", act_q0.size(), 2);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    act_q0.delete();
    bd[0] = rand_data();
    send_beat(bd[0], mk_head(3'd5, 3'd6, 16'd10), 1'b1);
    step();
    check("t6_q0_count", act_q0.size(), 1);
    if (act_q0.size() == 1)
      check("t6_head_entry", act_q0[0], mk_entry(3'd5, 3'd6, 16'd10, 5'd9, 1'b1, 1'b1, bd[0]));
    act_q0.delete();

    // Randomized packets against the packet-level model.
    err_exp = 0;
    map = 8'($urandom);
    rand_pf = 1'b1;
    for (int p = 0; p < 40; p++) begin
      logic [2:0] dst, src;
      int len, nb, exp_b, nwr, r;
      logic [DW-1:0] dq[$];
      dst = 3'($urandom_range(0, 7));
      src = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 19);
      len = (r == 0) ? 0 : $urandom_range(1, 200);
      exp_b = (len + 31) / 32;
      nb = (exp_b == 0) ? 1 : exp_b;
      if (r == 1) nb = nb + 1;
      else if (r == 2 && nb > 1) nb = nb - 1;
      for (int b = 0; b < nb; b++) begin
        dq.push_back(rand_data());
        send_beat(dq[b], mk_head(dst, src, 16'(len)), b == nb - 1);
        if ($urandom_range(0, 3) == 0) step();
      end
`ifdef P2P_ENQ_LEN_CHECK_EN
      if (len == 0) begin
        nwr = 0;
        err_exp++;
      end else begin
        nwr = (nb < exp_b) ? nb : exp_b;
        if (nb != exp_b) err_exp++;
      end
`else
      nwr = nb;
`endif
      for (int b = 0; b < nwr; b++) begin
        logic [EQW-1:0] e;
        e = mk_entry(dst, src, 16'(len), (b == nwr - 1) ? end_keep(len) : 5'd31,
                     b == nwr - 1, b == 0, dq[b]);
        if (map[dst]) exp_q1.push_back(e);
        else exp_q0.push_back(e);
      end
    end
    rand_pf = 1'b0;
    pf0 = 1'b0;
    pf1 = 1'b0;
    repeat (3) step();
    check("rand_q0_count", act_q0.size(), exp_q0.size());
    check("rand_q1_count", act_q1.size(), exp_q1.size());
    for (int i = 0; i < exp_q0.size(); i++)
      if (i < act_q0.size()) check($sformatf("rand_q0_entry%0d", i), act_q0[i], exp_q0[i]);
    for (int i = 0; i < exp_q1.size(); i++)
      if (i < act_q1.size()) check($sformatf("rand_q1_entry%0d", i), act_q1[i], exp_q1[i]);
    check("rand_err", err, 16'(err_exp));
    check("rand_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
